// File: rtl/bus_master_ctrl_pkg.sv
// Shared types for the main-bus master: FSM states, burst geometry and word typedefs.
package bus_master_ctrl_pkg;

  localparam int BURST_LEN = 4;

  typedef logic [15:0] word_t;
  typedef logic [11:0] offset_t;
  typedef logic [3:0]  page_t;
  typedef logic [63:0] burst_t;

  typedef enum logic [2:0] {
    BM_IDLE = 3'd0,
    BM_ADDR = 3'd1,
    BM_D1   = 3'd2,
    BM_D2   = 3'd3,
    BM_D3   = 3'd4,
    BM_D4   = 3'd5
  } bm_state_t;

  function automatic logic is_data_beat(bm_state_t s);
    return (s == BM_D1) || (s == BM_D2) || (s == BM_D3) || (s == BM_D4);
  endfunction

  function automatic logic [1:0] beat_idx(bm_state_t s);
    case (s)
      BM_D2:   return 2'd1;
      BM_D3:   return 2'd2;
      BM_D4:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/bus_master_ctrl_if.sv
// Processor request/response handshake plus the bus strobes of the main-bus master.
interface bus_master_ctrl_if;
  import bus_master_ctrl_pkg::*;

  logic   req_valid;
  logic   req_ready;
  logic   req_rw;
  word_t  req_addr;
  burst_t req_wdata;
  logic   rsp_valid;
  burst_t rsp_rdata;
  logic   AddrValid;
  logic   rw;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, AddrValid, rw
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, AddrValid, rw
  );

endinterface

// File: rtl/bus_master_ctrl_rd_assembler.sv
// Collects the four read beats and publishes them together so rsp_rdata only moves with rsp_valid.
module bus_master_ctrl_rd_assembler
  import bus_master_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cap_en,
  input  logic [1:0] beat,
  input  word_t      bus_word,
  output burst_t     rdata
);

  logic [47:0] stage_p0;

  // Beats 1..3 wait in stage_p0; beat 4 releases the whole burst at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_p0 <= '0;
      rdata    <= '0;
    end else if (cap_en) begin
      if (beat == 2'd3) begin
        rdata <= {bus_word, stage_p0};
      end else begin
        stage_p0[{beat, 4'b0000} +: 16] <= bus_word;
      end
    end
  end

endmodule

// File: rtl/bus_master_ctrl.sv
// Main-bus master: one address beat then four data beats per burst on the multiplexed AddrData bus.
// Optional transfer counters are built when BUS_MASTER_XFER_COUNT_EN is defined.
module bus_master_ctrl
  import bus_master_ctrl_pkg::*;
#(
  parameter int   BEATS   = BURST_LEN,
  parameter logic IDLE_RW = 1'b1
) (
  input  logic              clk,
  input  logic              resetH,
  bus_master_ctrl_if.master bus,
  inout  wire [15:0]        AddrData
`ifdef BUS_MASTER_XFER_COUNT_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  if (BEATS != BURST_LEN) begin : g_bad_beats
    $error("bus_master_ctrl: BEATS must be 4");
  end

  bm_state_t  state;
  logic       rw_lat;
  word_t      addr_lat;
  burst_t     wdata_lat;
  logic       rsp_valid_r;
  logic       accept;
  logic       drive_en;
  logic [1:0] beat;
  word_t      drive_word;
  burst_t     rsp_rdata;

  assign accept = bus.req_valid && bus.req_ready;
  assign beat   = beat_idx(state);

  always_ff @(posedge clk) begin
    if (resetH) begin
      state       <= BM_IDLE;
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= (state == BM_D4);
      unique case (state)
        BM_IDLE: if (bus.req_valid) state <= BM_ADDR;
        BM_ADDR: state <= BM_D1;
        BM_D1:   state <= BM_D2;
        BM_D2:   state <= BM_D3;
        BM_D3:   state <= BM_D4;
        BM_D4:   state <= BM_IDLE;
        default: state <= BM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rw_lat    <= bus.req_rw;
      addr_lat  <= bus.req_addr;
      wdata_lat <= bus.req_wdata;
    end
  end

  // The address goes out unmodified; the slave walks the four offsets itself.
  assign drive_en   = (state == BM_ADDR) || (is_data_beat(state) && !rw_lat);
  assign drive_word = (state == BM_ADDR) ? addr_lat : wdata_lat[{beat, 4'b0000} +: 16];
  assign AddrData   = drive_en ? drive_word : 16'hzzzz;

  assign bus.req_ready = (state == BM_IDLE) && !resetH;
  assign bus.AddrValid = (state == BM_ADDR);
  assign bus.rw        = (state == BM_IDLE) ? IDLE_RW : rw_lat;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata;

  bus_master_ctrl_rd_assembler u_rd_assembler (
    .clk      (clk),
    .rst      (resetH),
    .cap_en   (is_data_beat(state) && rw_lat),
    .beat     (beat),
    .bus_word (AddrData),
    .rdata    (rsp_rdata)
  );

`ifdef BUS_MASTER_XFER_COUNT_EN
  function automatic logic [15:0] sat_inc(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Counted on the edge into the completion cycle, so a reset before then drops the burst.
  always_ff @(posedge clk) begin
    if (resetH) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == BM_D4) begin
      if (rw_lat) rd_count <= sat_inc(rd_count);
      else        wr_count <= sat_inc(wr_count);
    end
  end
`endif

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Directed bench for bus_master_ctrl with a page-2 read slave; the bus is pulled up so a released bus reads 16'hFFFF.
module tb_bus_master_ctrl;
  import bus_master_ctrl_pkg::*;

  logic clk = 1'b0;
  logic resetH;
  always #5 clk = ~clk;

  bus_master_ctrl_if bif();
  wire [15:0] AddrData;

  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (AddrData[i]);
  end

`ifdef BUS_MASTER_XFER_COUNT_EN
  logic [15:0] rd_count, wr_count;
`endif

  bus_master_ctrl dut (
    .clk      (clk),
    .resetH   (resetH),
    .bus      (bif.master),
    .AddrData (AddrData)
`ifdef BUS_MASTER_XFER_COUNT_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  // Page-2 slave: answers reads on the four beats after its address phase.
  logic       slv_act = 1'b0;
  logic       slv_rd  = 1'b0;
  logic [11:0] slv_off = '0;
  logic [1:0]  slv_beat = '0;

  always @(posedge clk) begin
    if (resetH) begin
      slv_act <= 1'b0;
    end else if (bif.AddrValid && AddrData[15:12] == 4'h2) begin
      slv_act  <= 1'b1;
      slv_rd   <= bif.rw;
      slv_off  <= AddrData[11:0];
      slv_beat <= 2'd0;
    end else if (slv_act) begin
      slv_beat <= slv_beat + 2'd1;
      if (slv_beat == 2'd3) slv_act <= 1'b0;
    end
  end

  function automatic logic [15:0] slv_mem(logic [11:0] off);
    if (off >= 12'h010 && off <= 12'h013) return 16'h00A0 + 16'(off - 12'h010);
    return 16'hC000 | {4'h0, off};
  endfunction

  assign AddrData = (slv_act && slv_rd) ? slv_mem(slv_off + {10'b0, slv_beat}) : 16'hzzzz;

  int checks = 0;
  int failures = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rw_i, input logic [15:0] addr_i, input logic [63:0] wd_i);
    bif.req_valid = 1'b1;
    bif.req_rw    = rw_i;
    bif.req_addr  = addr_i;
    bif.req_wdata = wd_i;
    tick();
    bif.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    resetH        = 1'b1;
    bif.req_valid = 1'b1;
    bif.req_rw    = 1'b1;
    bif.req_addr  = 16'h2010;
    bif.req_wdata = '0;
    repeat (3) tick();
    checks++; if (bif.req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", bif.req_ready); end
    checks++; if (bif.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", bif.rsp_valid); end
    checks++; if (bif.rsp_rdata !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", bif.rsp_rdata); end
    checks++; if (bif.AddrValid !== 1'b0) begin failures++; $display("FAIL reset_addrvalid got=%b want=0", bif.AddrValid); end
    checks++; if (bif.rw !== 1'b1) begin failures++; $display("FAIL reset_rw got=%b want=1", bif.rw); end
    checks++; if (AddrData !== 16'hFFFF) begin failures++; $display("FAIL reset_bus_released got=%h want=ffff", AddrData); end
    resetH        = 1'b0;
    bif.req_valid = 1'b0;
    #1;
    checks++; if (bif.req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b want=1", bif.req_ready); end
    tick();
    checks++; if (bif.AddrValid !== 1'b0) begin failures++; $display("FAIL reset_req_ignored addrvalid got=%b want=0", bif.AddrValid); end
  endtask

  task automatic test_write;
    logic [63:0] wd;
    logic [15:0] exp;
    wd = 64'h4444_3333_2222_1111;
    issue(1'b0, 16'h2010, wd);
    checks++; if (bif.AddrValid !== 1'b1) begin failures++; $display("FAIL wr_addr_valid got=%b want=1", bif.AddrValid); end
    checks++; if (AddrData !== 16'h2010) begin failures++; $display("FAIL wr_addr_data got=%h want=2010", AddrData); end
    checks++; if (bif.rw !== 1'b0) begin failures++; $display("FAIL wr_addr_rw got=%b want=0", bif.rw); end
    checks++; if (bif.req_ready !== 1'b0) begin failures++; $display("FAIL wr_busy_ready got=%b want=0", bif.req_ready); end
    for (int n = 0; n < 4; n++) begin
      tick();
      exp = wd[n*16 +: 16];
      checks++; if (AddrData !== exp) begin failures++; $display("FAIL wr_beat%0d_data got=%h want=%h", n + 1, AddrData, exp); end
      checks++; if (bif.AddrValid !== 1'b0 || bif.rw !== 1'b0 || bif.rsp_valid !== 1'b0) begin
        failures++; $display("FAIL wr_beat%0d_ctrl got av=%b rw=%b rv=%b want av=0 rw=0 rv=0", n + 1, bif.AddrValid, bif.rw, bif.rsp_valid);
      end
    end
    tick();
    checks++; if (bif.rsp_valid !== 1'b1) begin failures++; $display("FAIL wr_rsp_valid got=%b want=1", bif.rsp_valid); end
    checks++; if (bif.rsp_rdata !== 64'h0) begin failures++; $display("FAIL wr_rdata_kept got=%h want=0", bif.rsp_rdata); end
    checks++; if (bif.rw !== 1'b1 || AddrData !== 16'hFFFF || bif.req_ready !== 1'b1) begin
      failures++; $display("FAIL wr_done_idle got rw=%b bus=%h ready=%b want rw=1 bus=ffff ready=1", bif.rw, AddrData, bif.req_ready);
    end
    tick();
    checks++; if (bif.rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_rsp_one_cycle got=%b want=0", bif.rsp_valid); end
  endtask

  task automatic test_read;
    logic [15:0] exp;
    issue(1'b1, 16'h2010, 64'h0);
    checks++; if (AddrData !== 16'h2010 || bif.rw !== 1'b1 || bif.AddrValid !== 1'b1) begin
      failures++; $display("FAIL rd_addr_phase got bus=%h rw=%b av=%b want 2010 1 1", AddrData, bif.rw, bif.AddrValid);
    end
    for (int n = 0; n < 4; n++) begin
      tick();
      exp = 16'h00A0 + 16'(n);
      checks++; if (AddrData !== exp) begin failures++; $display("FAIL rd_beat%0d_bus got=%h want=%h", n + 1, AddrData, exp); end
      checks++; if (bif.rsp_rdata !== 64'h0) begin failures++; $display("FAIL rd_beat%0d_rdata_held got=%h want=0", n + 1, bif.rsp_rdata); end
    end
    tick();
    checks++; if (bif.rsp_valid !== 1'b1) begin failures++; $display("FAIL rd_rsp_valid got=%b want=1", bif.rsp_valid); end
    checks++; if (bif.rsp_rdata !== 64'h00A3_00A2_00A1_00A0) begin failures++; $display("FAIL rd_rdata got=%h want=00a300a200a100a0", bif.rsp_rdata); end
    tick();
    checks++; if (bif.rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_rsp_one_cycle got=%b want=0", bif.rsp_valid); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] wd;
    logic [15:0] exp;
    wd = 64'hDDDD_CCCC_BBBB_AAAA;
    bif.req_valid = 1'b1;
    bif.req_rw    = 1'b0;
    bif.req_addr  = 16'h2020;
    bif.req_wdata = wd;
    tick();
    checks++; if (bif.AddrValid !== 1'b1 || AddrData !== 16'h2020) begin
      failures++; $display("FAIL b2b_first_addr got av=%b bus=%h want 1 2020", bif.AddrValid, AddrData);
    end
    bif.req_rw    = 1'b1;
    bif.req_wdata = 64'h0;
    for (int n = 0; n < 4; n++) begin
      tick();
      exp = wd[n*16 +: 16];
      checks++; if (AddrData !== exp || $isunknown(AddrData)) begin failures++; $display("FAIL b2b_wr_beat%0d got=%h want=%h", n + 1, AddrData, exp); end
      checks++; if (bif.req_ready !== 1'b0 || bif.AddrValid !== 1'b0) begin
        failures++; $display("FAIL b2b_busy%0d got ready=%b av=%b want 0 0", n + 1, bif.req_ready, bif.AddrValid);
      end
    end
    tick();
    checks++; if (bif.rsp_valid !== 1'b1 || bif.req_ready !== 1'b1 || bif.AddrValid !== 1'b0) begin
      failures++; $display("FAIL b2b_completion got rv=%b ready=%b av=%b want 1 1 0", bif.rsp_valid, bif.req_ready, bif.AddrValid);
    end
    checks++; if (bif.rsp_rdata !== 64'h00A3_00A2_00A1_00A0) begin failures++; $display("FAIL b2b_wr_rdata_kept got=%h want=00a300a200a100a0", bif.rsp_rdata); end
    tick();
    bif.req_valid = 1'b0;
    checks++; if (bif.AddrValid !== 1'b1 || AddrData !== 16'h2020 || bif.rw !== 1'b1) begin
      failures++; $display("FAIL b2b_second_addr_at_6 got av=%b bus=%h rw=%b want 1 2020 1", bif.AddrValid, AddrData, bif.rw);
    end
    for (int n = 0; n < 4; n++) begin
      tick();
      exp = 16'hC020 + 16'(n);
      checks++; if (AddrData !== exp) begin failures++; $display("FAIL b2b_rd_beat%0d got=%h want=%h", n + 1, AddrData, exp); end
    end
    tick();
    checks++; if (bif.rsp_valid !== 1'b1 || bif.rsp_rdata !== 64'hC023_C022_C021_C020) begin
      failures++; $display("FAIL b2b_rd_rsp got rv=%b rdata=%h want 1 c023c022c021c020", bif.rsp_valid, bif.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_wrong_page;
    issue(1'b1, 16'h5000, 64'h0);
    checks++; if (AddrData !== 16'h5000 || bif.AddrValid !== 1'b1) begin
      failures++; $display("FAIL wp_addr got bus=%h av=%b want 5000 1", AddrData, bif.AddrValid);
    end
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++; if (AddrData !== 16'hFFFF) begin failures++; $display("FAIL wp_beat%0d_released got=%h want=ffff", n + 1, AddrData); end
    end
    tick();
    checks++; if (bif.rsp_valid !== 1'b1 || bif.req_ready !== 1'b1) begin
      failures++; $display("FAIL wp_complete got rv=%b ready=%b want 1 1", bif.rsp_valid, bif.req_ready);
    end
    checks++; if (bif.rsp_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL wp_rdata_floating got=%h want=ffffffffffffffff", bif.rsp_rdata); end
    tick();
  endtask

  task automatic test_reset_mid;
    issue(1'b0, 16'h2030, 64'h1234_5678_9ABC_DEF0);
    tick();
    tick();
    checks++; if (AddrData !== 16'h9ABC) begin failures++; $display("FAIL rm_d2_data got=%h want=9abc", AddrData); end
    resetH = 1'b1;
    tick();
    resetH = 1'b0;
    #1;
    checks++; if (bif.AddrValid !== 1'b0 || bif.rw !== 1'b1 || AddrData !== 16'hFFFF) begin
      failures++; $display("FAIL rm_idle got av=%b rw=%b bus=%h want 0 1 ffff", bif.AddrValid, bif.rw, AddrData);
    end
    checks++; if (bif.rsp_valid !== 1'b0 || bif.rsp_rdata !== 64'h0 || bif.req_ready !== 1'b1) begin
      failures++; $display("FAIL rm_rsp got rv=%b rdata=%h ready=%b want 0 0 1", bif.rsp_valid, bif.rsp_rdata, bif.req_ready);
    end
    tick();
    checks++; if (bif.rsp_valid !== 1'b0 || bif.AddrValid !== 1'b0) begin
      failures++; $display("FAIL rm_no_pulse got rv=%b av=%b want 0 0", bif.rsp_valid, bif.AddrValid);
    end
    issue(1'b1, 16'h2000, 64'h0);
    checks++; if (AddrData !== 16'h2000 || bif.AddrValid !== 1'b1) begin
      failures++; $display("FAIL rm_next_addr got bus=%h av=%b want 2000 1", AddrData, bif.AddrValid);
    end
    repeat (5) tick();
    checks++; if (bif.rsp_valid !== 1'b1 || bif.rsp_rdata !== 64'hC003_C002_C001_C000) begin
      failures++; $display("FAIL rm_next_read got rv=%b rdata=%h want 1 c003c002c001c000", bif.rsp_valid, bif.rsp_rdata);
    end
  endtask

`ifdef BUS_MASTER_XFER_COUNT_EN
  task automatic do_burst(input logic rw_i, input logic [15:0] addr_i);
    issue(rw_i, addr_i, 64'h5555_6666_7777_8888);
    repeat (5) tick();
  endtask

  task automatic test_xfer_count;
    do_burst(1'b1, 16'h2010);
    do_burst(1'b0, 16'h2040);
    do_burst(1'b1, 16'h2000);
    do_burst(1'b0, 16'h2050);
    checks++; if (rd_count !== 16'd3 || wr_count !== 16'd2) begin
      failures++; $display("FAIL cnt_totals got rd=%0d wr=%0d want 3 2", rd_count, wr_count);
    end
    issue(1'b1, 16'h2010, 64'h0);
    tick();
    resetH = 1'b1;
    tick();
    resetH = 1'b0;
    repeat (5) tick();
    checks++; if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
      failures++; $display("FAIL cnt_abort got rd=%0d wr=%0d want 0 0", rd_count, wr_count);
    end
    force dut.rd_count = 16'hFFFF;
    tick();
    release dut.rd_count;
    do_burst(1'b1, 16'h2010);
    checks++; if (rd_count !== 16'hFFFF || wr_count !== 16'd0) begin
      failures++; $display("FAIL cnt_saturate got rd=%h wr=%h want ffff 0000", rd_count, wr_count);
    end
  endtask
`endif

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bif.req_valid = 1'b0;
    bif.req_rw    = 1'b0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;
    resetH        = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_wrong_page();
    test_reset_mid();
`ifdef BUS_MASTER_XFER_COUNT_EN
    test_xfer_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
